// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: defaults,
// pointer-width helper and elaboration-time range checks for thresholds.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    // Pointers carry one extra wrap bit above the memory address bits.
    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    // True when lo <= v <= hi; used to reject bad threshold parameters.
    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write port and a registered read port
// with read-enable. The read register resets to zero; the array does not.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the write word; storage is never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read data, held between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags. Status outputs depend on
// the registered pointers only.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = (1 << ADDR_W) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              SYSCLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic              RD_EN,
    input  logic [DATA_W-1:0] FIFO_IN,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] FIFO_OUT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ptr_w(ADDR_W);
    localparam logic [PTR_W-1:0] AF_CNT = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_CNT = PTR_W'(AE_LEVEL);

    if (!in_range(AF_LEVEL, 1, DEPTH)) begin : g_af_bad
        $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
    end
    if (!in_range(AE_LEVEL, 0, DEPTH - 1)) begin : g_ae_bad
        $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Full when only the wrap bits differ; empty when pointers match.
    assign FULL         = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) &&
                          (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]);
    assign EMPTY        = (w_ptr == r_ptr);
    assign COUNT        = w_ptr - r_ptr;
    assign ALMOST_FULL  = (COUNT >= AF_CNT);
    assign ALMOST_EMPTY = (COUNT <= AE_CNT);

    // Acceptance uses pre-edge FULL/EMPTY, so a same-cycle partner never
    // rescues a rejected access.
    assign wr_ok = WR_EN & ~FULL;
    assign rd_ok = RD_EN & ~EMPTY;

    // Pointer advance on accepted accesses; reset discards all contents.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_ok) w_ptr <= w_ptr + 1'b1;
            if (rd_ok) r_ptr <= r_ptr + 1'b1;
        end
    end

    // Sticky error flags; a fresh error beats a coincident clear.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            OVERFLOW  <= (WR_EN & FULL)  | (OVERFLOW  & ~CLR_ERR);
            UNDERFLOW <= (RD_EN & EMPTY) | (UNDERFLOW & ~CLR_ERR);
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (SYSCLK),
        .rst     (RST),
        .wr_en   (wr_ok & ~RST),
        .wr_addr (w_ptr[ADDR_W-1:0]),
        .wr_data (FIFO_IN),
        .rd_en   (rd_ok),
        .rd_addr (r_ptr[ADDR_W-1:0]),
        .rd_data (FIFO_OUT)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default 4x8 instance and a 16x16
// instance with thresholds 12/3.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default parameters
    logic       a_rst = 1'b0, a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
    logic [7:0] a_din = '0;
    logic [7:0] a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_cnt;

    sync_fifo_param u_a (
        .SYSCLK(clk), .RST(a_rst), .WR_EN(a_wr), .RD_EN(a_rd),
        .FIFO_IN(a_din), .CLR_ERR(a_clr), .FIFO_OUT(a_dout),
        .FULL(a_full), .EMPTY(a_empty), .ALMOST_FULL(a_af),
        .ALMOST_EMPTY(a_ae), .COUNT(a_cnt), .OVERFLOW(a_ovf),
        .UNDERFLOW(a_udf)
    );

    // Instance B: 16 bits x 16 words, AF=12, AE=3
    logic        b_rst = 1'b0, b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
    logic [15:0] b_din = '0;
    logic [15:0] b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [4:0]  b_cnt;

    sync_fifo_param #(
        .DATA_W(16), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(3)
    ) u_b (
        .SYSCLK(clk), .RST(b_rst), .WR_EN(b_wr), .RD_EN(b_rd),
        .FIFO_IN(b_din), .CLR_ERR(b_clr), .FIFO_OUT(b_dout),
        .FULL(b_full), .EMPTY(b_empty), .ALMOST_FULL(b_af),
        .ALMOST_EMPTY(b_ae), .COUNT(b_cnt), .OVERFLOW(b_ovf),
        .UNDERFLOW(b_udf)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // ---------------- Instance A ----------------
        a_rst = 1'b1; b_rst = 1'b1;
        tick();
        a_rst = 1'b0; b_rst = 1'b0;
        check("rst_cnt",   a_cnt,   0);
        check("rst_empty", a_empty, 1);
        check("rst_full",  a_full,  0);
        check("rst_ae",    a_ae,    1);
        check("rst_af",    a_af,    0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_udf",   a_udf,   0);
        check("rst_dout",  a_dout,  0);

        // Fill with 11,22,33,44
        a_wr = 1'b1; a_din = 8'h11; tick();
        check("w1_cnt", a_cnt, 1); check("w1_ae", a_ae, 1); check("w1_empty", a_empty, 0);
        a_din = 8'h22; tick();
        check("w2_cnt", a_cnt, 2); check("w2_ae", a_ae, 0); check("w2_af", a_af, 0);
        a_din = 8'h33; tick();
        check("w3_cnt", a_cnt, 3); check("w3_af", a_af, 1); check("w3_full", a_full, 0);
        a_din = 8'h44; tick();
        check("w4_cnt", a_cnt, 4); check("w4_full", a_full, 1);
        a_din = 8'h55; tick();
        check("w5_ovf", a_ovf, 1); check("w5_cnt", a_cnt, 4);
        a_wr = 1'b0;

        // Drain: overflow write must not have disturbed contents
        a_rd = 1'b1;
        tick(); check("r1_dout", a_dout, 8'h11);
        tick(); check("r2_dout", a_dout, 8'h22);
        tick(); check("r3_dout", a_dout, 8'h33);
        tick(); check("r4_dout", a_dout, 8'h44);
        check("r4_empty", a_empty, 1); check("r4_cnt", a_cnt, 0);
        tick();
        check("r5_udf", a_udf, 1); check("r5_dout", a_dout, 8'h44);
        a_rd = 1'b0;

        // Clear both errors with no new error
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        check("clr_ovf", a_ovf, 0); check("clr_udf", a_udf, 0);

        // Wrap-around at occupancy 2
        a_wr = 1'b1; a_din = 8'h00; tick();
        a_din = 8'h01; tick();
        check("wrap_pre_cnt", a_cnt, 2);
        a_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_din = 8'(i + 2);
            tick();
            check($sformatf("wrap_dout%0d", i), a_dout, i);
            check($sformatf("wrap_cnt%0d", i),  a_cnt,  2);
        end
        a_wr = 1'b0;
        tick(); check("wrap_d10", a_dout, 8'h0A);
        tick(); check("wrap_d11", a_dout, 8'h0B);
        a_rd = 1'b0;
        check("wrap_ovf", a_ovf, 0); check("wrap_udf", a_udf, 0);
        check("wrap_empty", a_empty, 1);

        // Simultaneous write+read while empty
        a_wr = 1'b1; a_rd = 1'b1; a_din = 8'hA5; tick();
        a_wr = 1'b0; a_rd = 1'b0;
        check("se_cnt", a_cnt, 1); check("se_udf", a_udf, 1);
        check("se_dout", a_dout, 8'h0B);
        a_rd = 1'b1; tick(); a_rd = 1'b0;
        check("se_rd", a_dout, 8'hA5);

        // Fill, then simultaneous write+read while full
        a_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_din = 8'(8'hC0 + i); tick();
        end
        check("sf_full", a_full, 1);
        a_rd = 1'b1; a_din = 8'hEE; tick(); a_rd = 1'b0;
        check("sf_cnt", a_cnt, 3); check("sf_ovf", a_ovf, 1);
        check("sf_dout", a_dout, 8'hC0);
        a_din = 8'hC4; tick();
        check("sf_refull", a_full, 1);
        // Clear coincident with a new overflow: overflow wins
        a_clr = 1'b1; a_din = 8'hEF; tick();
        check("clr_coinc_ovf", a_ovf, 1); check("clr_coinc_udf", a_udf, 0);
        a_wr = 1'b0; tick(); a_clr = 1'b0;
        check("clr_after_ovf", a_ovf, 0);
        a_rd = 1'b1;
        tick(); check("sf_r1", a_dout, 8'hC1);
        tick(); check("sf_r2", a_dout, 8'hC2);
        tick(); check("sf_r3", a_dout, 8'hC3);
        tick(); check("sf_r4", a_dout, 8'hC4);
        a_rd = 1'b0;
        check("sf_empty", a_empty, 1);

        // ---------------- Instance B ----------------
        check("b_rst_ae", b_ae, 1); check("b_rst_af", b_af, 0);
        b_wr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b_din = 16'(16'h1000 + i); tick();
            check($sformatf("b_w%0d_cnt", i), b_cnt, i + 1);
            check($sformatf("b_w%0d_ae", i),  b_ae,  (i + 1) <= 3);
        end
        b_wr = 1'b0; b_rd = 1'b1; tick(); b_rd = 1'b0;
        check("b_pre_rst_dout", b_dout, 16'h1000);
        b_wr = 1'b1; b_rd = 1'b1; b_clr = 1'b1; b_rst = 1'b1; b_din = 16'hDEAD;
        tick();
        b_rst = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
        check("b_rst_cnt",   b_cnt,   0);
        check("b_rst_empty", b_empty, 1);
        check("b_rst_dout",  b_dout,  0);
        for (int i = 0; i < 16; i++) begin
            b_din = 16'(16'h2000 + i); tick();
            check($sformatf("b_f%0d_cnt", i), b_cnt, i + 1);
            check($sformatf("b_f%0d_af", i),  b_af,  (i + 1) >= 12);
            check($sformatf("b_f%0d_ae", i),  b_ae,  (i + 1) <= 3);
        end
        b_wr = 1'b0;
        check("b_full", b_full, 1); check("b_ovf", b_ovf, 0);
        b_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("b_r%0d_dout", i), b_dout, 16'h2000 + i);
            check($sformatf("b_r%0d_af", i),   b_af,   (15 - i) >= 12);
            check($sformatf("b_r%0d_ae", i),   b_ae,   (15 - i) <= 3);
        end
        b_rd = 1'b0;
        check("b_end_empty", b_empty, 1); check("b_end_udf", b_udf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's 4×8 FIFO buffer, generalised in data width and depth. Adds occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Sits between byte/word producers and consumers in the same clock domain, e.g. UART/SPI front-ends feeding the processing datapath.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (≥1)
- ADDR_W, 2, log2 of depth; DEPTH = 2**ADDR_W (ADDR_W ≥ 1)
- AF_LEVEL, DEPTH-1, ALMOST_FULL asserts when COUNT ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, ALMOST_EMPTY asserts when COUNT ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- SYSCLK  in  1  clock, all logic on rising edge
- RST  in  1  reset; one clock, synchronous and active-high
- WR_EN  in  1  write request
- RD_EN  in  1  read request
- FIFO_IN  in  DATA_W  write data, sampled when a write is accepted
- CLR_ERR  in  1  clears OVERFLOW and UNDERFLOW
- FIFO_OUT  out  DATA_W  registered read data
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- ALMOST_FULL  out  1  COUNT ≥ AF_LEVEL
- ALMOST_EMPTY  out  1  COUNT ≤ AE_LEVEL
- COUNT  out  ADDR_W+1  current occupancy, 0..DEPTH
- OVERFLOW  out  1  sticky: write attempted while FULL
- UNDERFLOW  out  1  sticky: read attempted while EMPTY

## Operation
- Pointers w_ptr, r_ptr are ADDR_W+1 bits; low ADDR_W bits address memory, MSB is the wrap bit. Increment mod 2**(ADDR_W+1).
- FULL: MSBs differ, low bits equal. EMPTY: pointers equal. COUNT = w_ptr − r_ptr mod 2**(ADDR_W+1).
- Write accepted (wr_ok) = WR_EN & ~FULL; stores FIFO_IN at w_ptr, w_ptr+1.
- Read accepted (rd_ok) = RD_EN & ~EMPTY; FIFO_OUT ← mem[r_ptr], r_ptr+1.
- FULL/EMPTY evaluated on pre-edge state: write while FULL is rejected even if a read is accepted the same cycle; read while EMPTY is rejected even if a write is accepted the same cycle.
- Simultaneous accepted read and write: both happen, COUNT unchanged.
- No accepted read: FIFO_OUT holds its value.
- OVERFLOW set on WR_EN & FULL; UNDERFLOW set on RD_EN & EMPTY. Both cleared by CLR_ERR; a new error in the same cycle as CLR_ERR wins (flag stays 1). Rejected accesses change no pointer or memory.
- Status outputs (FULL, EMPTY, ALMOST_*, COUNT) are combinational from registered pointers only, no input-to-output paths.

## Timing
- Reset values: w_ptr=r_ptr=0, FIFO_OUT=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1 (AE_LEVEL≥0), ALMOST_FULL=0, OVERFLOW=UNDERFLOW=0. Memory contents not reset.
- RST mid-operation: all stored words discarded on that edge; RST overrides WR_EN/RD_EN/CLR_ERR.
- Read latency: 1 cycle; data valid on FIFO_OUT after the edge on which rd_ok was 1.
- Write-to-read: word written at edge N is readable (EMPTY=0) after edge N; earliest accepted read at edge N+1, data on FIFO_OUT after N+1.
- Flag/COUNT updates visible after the edge that moves a pointer.
- Throughput: one write and one read per cycle sustained.

## Structure
- Shared package fifo_pkg: default DATA_W/ADDR_W, pointer-width function (ADDR_W+1), threshold-range checks (elaboration-time error if AF_LEVEL or AE_LEVEL out of range).
- One sub-module: fifo_mem — simple dual-port RAM, DEPTH×DATA_W, synchronous write port, registered read port with read-enable. Top holds pointers, flags, error logic.

## Test plan
- Reset, then write 0x11,0x22,0x33,0x44 (default params) -> FULL=1 after 4th edge, COUNT=4, ALMOST_FULL=1 from COUNT=3; 5th write -> OVERFLOW=1, contents unchanged.
- Read 4 words from full FIFO -> FIFO_OUT 0x11,0x22,0x33,0x44 one cycle after each accepted read; EMPTY=1, COUNT=0; extra read -> UNDERFLOW=1, FIFO_OUT holds 0x44.
- Wrap-around: 10 cycles of write+read interleaved with occupancy 2, data incrementing from 0x00 -> output sequence in order, no flag errors, COUNT steady at 2 during simultaneous ops.
- Simultaneous WR_EN+RD_EN while EMPTY -> write accepted, COUNT=1, UNDERFLOW=1; while FULL -> read accepted, write rejected, COUNT=3, OVERFLOW=1.
- CLR_ERR with OVERFLOW=1 and no new error -> OVERFLOW=0 next cycle; CLR_ERR coincident with WR_EN&FULL -> OVERFLOW stays 1.
- DATA_W=16, ADDR_W=4, AF_LEVEL=12, AE_LEVEL=3: fill 16 words, RST asserted after 7 writes -> COUNT=0, EMPTY=1, FIFO_OUT=0; thresholds toggle exactly at COUNT 12 and 3.
